// File: rtl/pico_io_sequencer.sv
// Switch/LED operand sequencer between board I/O and the picoMIPS core.
// Captures NIN operands on ready-switch toggles, starts the core, then steps NOUT results onto the LEDs.
module pico_io_sequencer #(
  parameter int unsigned N           = 8,
  parameter int unsigned NIN         = 2,
  parameter int unsigned NOUT        = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                nReset,
  input  logic [N-1:0]        sw_data,
  input  logic                sw_ready,
  output logic [NIN*N-1:0]    op_data,
  output logic                core_start,
  input  logic                core_done,
  input  logic [NOUT*N-1:0]   res_data,
  output logic [N-1:0]        led,
  output logic                busy,
  output logic                overrun
);

  localparam int unsigned MAXC = (NIN > NOUT) ? NIN : NOUT;
  // idx must reach NOUT in SHOW, so it is sized to hold MAXC inclusive
  localparam int unsigned IW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {LOAD, START, COMPUTE, SHOW} state_t;

  state_t                       state, state_nxt;
  logic [IW-1:0]                idx, idx_nxt;
  logic [NIN*N-1:0]             op_nxt;
  logic [NOUT*N-1:0]            res_buf, res_nxt;
  logic [N-1:0]                 led_nxt;
  logic                         overrun_nxt, core_start_nxt, busy_nxt;

  logic [SYNC_STAGES-1:0]       rdy_sync;
  logic [SYNC_STAGES-1:0][N-1:0] dat_sync;
  logic                         rdy_dly;
  logic [SYNC_STAGES:0]         arm;
  logic                         tog;
  logic [N-1:0]                 data;

  // Toggles are suppressed until the synchroniser holds real switch state, so a switch already high at release is not an edge
  assign tog  = arm[SYNC_STAGES] & (rdy_sync[SYNC_STAGES-1] ^ rdy_dly);
  assign data = dat_sync[SYNC_STAGES-1];

  // State and datapath registers
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state      <= LOAD;
      idx        <= '0;
      op_data    <= '0;
      res_buf    <= '0;
      led        <= '0;
      overrun    <= 1'b0;
      core_start <= 1'b0;
      busy       <= 1'b0;
      rdy_sync   <= '0;
      dat_sync   <= '0;
      rdy_dly    <= 1'b0;
      arm        <= '0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      op_data    <= op_nxt;
      res_buf    <= res_nxt;
      led        <= led_nxt;
      overrun    <= overrun_nxt;
      core_start <= core_start_nxt;
      busy       <= busy_nxt;
      rdy_sync   <= {rdy_sync[SYNC_STAGES-2:0], sw_ready};
      dat_sync   <= {dat_sync[SYNC_STAGES-2:0], sw_data};
      rdy_dly    <= rdy_sync[SYNC_STAGES-1];
      arm        <= {arm[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:    if (tog && idx == IW'(NIN - 1)) state_nxt = START;
      START:   state_nxt = COMPUTE;
      COMPUTE: if (core_done) state_nxt = SHOW;
      SHOW:    if (tog && idx == IW'(NOUT)) state_nxt = (NIN == 1) ? START : LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    idx_nxt        = idx;
    op_nxt         = op_data;
    res_nxt        = res_buf;
    led_nxt        = led;
    overrun_nxt    = overrun;
    core_start_nxt = (state_nxt == START);
    busy_nxt       = (state_nxt == START) || (state_nxt == COMPUTE);
    unique case (state)
      LOAD: begin
        if (tog) begin
          for (int k = 0; k < NIN; k++)
            if (idx == IW'(k)) op_nxt[k*N +: N] = data;
          led_nxt = data;
          idx_nxt = (idx == IW'(NIN - 1)) ? '0 : idx + IW'(1);
        end
      end
      START: begin
        if (tog) overrun_nxt = 1'b1;
      end
      COMPUTE: begin
        if (tog) overrun_nxt = 1'b1;
        if (core_done) begin
          res_nxt = res_data;
          idx_nxt = '0;
        end
      end
      SHOW: begin
        if (tog) begin
          if (idx == IW'(NOUT)) begin
            op_nxt[N-1:0] = data;
            led_nxt       = data;
            idx_nxt       = (NIN == 1) ? '0 : IW'(1);
          end else begin
            for (int k = 0; k < NOUT; k++)
              if (idx == IW'(k)) led_nxt = res_buf[k*N +: N];
            idx_nxt = idx + IW'(1);
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pico_io_sequencer.sv
// Randomised self-checking bench for pico_io_sequencer (N=8, NIN=2, NOUT=2) with an add/subtract core model.
module tb_pico_io_sequencer;

  localparam int P_LOAD = 0;
  localparam int P_BUSY = 1;
  localparam int P_SHOW = 2;

  logic        clk = 1'b0;
  logic        nReset;
  logic [7:0]  sw_data;
  logic        sw_ready;
  logic [15:0] op_data;
  logic        core_start;
  logic        core_done;
  logic [15:0] res_data;
  logic [7:0]  led;
  logic        busy;
  logic        overrun;

  int n_chk = 0;
  int n_err = 0;
  int starts = 0;

  // User-step level reference model
  int         m_phase;
  int         m_cnt;
  logic [7:0] m_ops [2];
  logic [7:0] m_res [2];
  logic [7:0] m_led;
  logic       m_ovr;

  pico_io_sequencer #(.N(8), .NIN(2), .NOUT(2), .SYNC_STAGES(2)) dut (
    .clk(clk), .nReset(nReset), .sw_data(sw_data), .sw_ready(sw_ready),
    .op_data(op_data), .core_start(core_start), .core_done(core_done),
    .res_data(res_data), .led(led), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Core: res0 = op0 + op1, res1 = op0 - op1, done ten cycles after start
  initial begin
    logic [7:0] a, b;
    core_done = 1'b0;
    res_data  = '0;
    forever begin
      @(negedge clk);
      if (core_start) begin
        starts++;
        a = op_data[7:0];
        b = op_data[15:8];
        repeat (10) @(negedge clk);
        core_done = 1'b1;
        res_data  = {8'(a - b), 8'(a + b)};
        @(negedge clk);
        core_done = 1'b0;
        res_data  = 16'($urandom);
      end
    end
  end

  task automatic model_reset();
    m_phase = P_LOAD; m_cnt = 0; m_ops[0] = '0; m_ops[1] = '0;
    m_res[0] = '0; m_res[1] = '0; m_led = '0; m_ovr = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".led"},     32'(led),     32'(m_led));
    check({tag, ".op_data"}, 32'(op_data), 32'({m_ops[1], m_ops[0]}));
    check({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
    check({tag, ".busy"},    32'(busy),    32'(m_phase == P_BUSY));
  endtask

  // One user step: set data, flip ready, wait until the led echo has landed
  task automatic do_tog(input logic [7:0] d);
    logic entered;
    entered = 1'b0;
    sw_data = d;
    @(negedge clk);
    sw_ready = ~sw_ready;
    repeat (3) @(negedge clk);
    case (m_phase)
      P_LOAD: begin
        m_ops[m_cnt] = d; m_led = d; m_cnt++;
        if (m_cnt == 2) begin m_phase = P_BUSY; m_cnt = 0; entered = 1'b1; end
      end
      P_BUSY: m_ovr = 1'b1;
      default: begin
        if (m_cnt < 2) begin m_led = m_res[m_cnt]; m_cnt++; end
        else begin m_ops[0] = d; m_led = d; m_cnt = 1; m_phase = P_LOAD; end
      end
    endcase
    check_outputs("tog");
    if (entered) begin
      check("core_start_pulse", 32'(core_start), 32'd1);
      @(negedge clk);
      check("core_start_single", 32'(core_start), 32'd0);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && busy; i++) @(negedge clk);
    check("done_wait", 32'(busy), 32'd0);
    m_res[0] = m_ops[0] + m_ops[1];
    m_res[1] = m_ops[0] - m_ops[1];
    m_phase = P_SHOW; m_cnt = 0;
    check_outputs("done");
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".led"},        32'(led),        32'd0);
    check({tag, ".op_data"},    32'(op_data),    32'd0);
    check({tag, ".busy"},       32'(busy),       32'd0);
    check({tag, ".overrun"},    32'(overrun),    32'd0);
    check({tag, ".core_start"}, 32'(core_start), 32'd0);
  endtask

  initial begin
    int s0;
    model_reset();
    nReset = 1'b0; sw_ready = 1'b1; sw_data = 8'hAA;
    repeat (3) @(negedge clk);
    check_reset_vals("in_reset");
    nReset = 1'b1;
    repeat (8) @(negedge clk);
    check_reset_vals("after_release");

    // Zero operands
    do_tog(8'h00); do_tog(8'h00); wait_done();
    do_tog(8'h5A); do_tog(8'hA5);

    // Signed operands, then back-to-back set
    do_tog(8'h05); do_tog(8'hFC);
    check("signed_op_data", 32'(op_data), 32'h0000FC05);
    wait_done();
    do_tog(8'h00); check("signed_res0", 32'(led), 32'h01);
    do_tog(8'h00); check("signed_res1", 32'(led), 32'h09);
    do_tog(8'h10); do_tog(8'hF4); wait_done();
    do_tog(8'h00); check("b2b_res0", 32'(led), 32'h04);
    do_tog(8'h00); check("b2b_res1", 32'(led), 32'h1C);

    // Overrun during COMPUTE, sticky through the next set
    do_tog(8'h33); do_tog(8'h11); do_tog(8'h77);
    check("overrun_set", 32'(overrun), 32'd1);
    wait_done(); do_tog(8'h00); do_tog(8'h00);
    do_tog(8'h21); do_tog(8'h12); wait_done(); do_tog(8'h00); do_tog(8'h00);

    // Mid-compute reset; the late done must be ignored
    do_tog(8'h44); do_tog(8'h22);
    repeat (3) @(negedge clk);
    s0 = starts;
    nReset = 1'b0;
    @(negedge clk);
    check_reset_vals("mid_reset");
    repeat (2) @(negedge clk);
    nReset = 1'b1;
    model_reset();
    repeat (20) @(negedge clk);
    check_reset_vals("late_done");
    check("no_restart", 32'(starts), 32'(s0));

    // Randomised sets with occasional overrun toggles
    for (int s = 0; s < 12; s++) begin
      do_tog(8'($urandom)); do_tog(8'($urandom));
      if ($urandom_range(3) == 0) do_tog(8'($urandom));
      wait_done();
      do_tog(8'($urandom)); do_tog(8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
